// File: rtl/aclock_pkg.sv
// Shared constants and types for the Aclock button front end.
// State codes, BCD limits and digit field widths.
package aclock_pkg;

    localparam int HT_W = 2;
    localparam int DG_W = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_T_HOUR   = 3'd1;
    localparam logic [2:0] ST_T_MIN    = 3'd2;
    localparam logic [2:0] ST_A_HOUR   = 3'd3;
    localparam logic [2:0] ST_A_MIN    = 3'd4;
    localparam logic [2:0] ST_COMMIT_T = 3'd5;
    localparam logic [2:0] ST_COMMIT_A = 3'd6;

    localparam logic [HT_W-1:0] HOUR_MAX_TENS       = 2'd2;
    localparam logic [DG_W-1:0] HOUR_MAX_UNITS_AT_2 = 4'd3;
    localparam logic [DG_W-1:0] MIN_MAX_TENS        = 4'd5;
    localparam logic [DG_W-1:0] DIGIT_MAX           = 4'd9;

    typedef struct packed {
        logic [HT_W-1:0] h1;
        logic [DG_W-1:0] h0;
        logic [DG_W-1:0] m1;
        logic [DG_W-1:0] m0;
    } hhmm_t;

endpackage

// File: rtl/aclock_time_setter_if.sv
// Link between the button front end and the Aclock core.
// master = front end, slave = core.
interface aclock_time_setter_if;
    import aclock_pkg::*;

    logic            Alarm;
    logic [HT_W-1:0] H_out1;
    logic [DG_W-1:0] H_out0;
    logic [DG_W-1:0] M_out1;
    logic [DG_W-1:0] M_out0;
    logic [HT_W-1:0] H_in1;
    logic [DG_W-1:0] H_in0;
    logic [DG_W-1:0] M_in1;
    logic [DG_W-1:0] M_in0;
    logic            LD_time;
    logic            LD_alarm;
    logic            AL_ON;
    logic            STOP_al;

    modport master (
        input  Alarm, H_out1, H_out0, M_out1, M_out0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, AL_ON, STOP_al
    );

    modport slave (
        output Alarm, H_out1, H_out0, M_out1, M_out0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, AL_ON, STOP_al
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus stability filter.
// press is a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aclock_time_setter.sv
// Button front end for the Aclock core: time/alarm edit FSM,
// BCD incrementers, auto-repeat and edit timeout.
module aclock_time_setter
    import aclock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_RATE     = 3,
    parameter int TIMEOUT_CYCLES  = 100
) (
    input logic clk,
    input logic reset,
    input logic btn_mode,
    input logic btn_alarm,
    input logic btn_inc,
    input logic btn_arm,
    aclock_time_setter_if.master core
);

    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic lvl_mode, lvl_alarm, lvl_inc, lvl_arm;
    logic p_mode, p_alarm, p_inc, p_arm;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .raw(btn_mode),
        .level(lvl_mode), .press(p_mode)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alarm (
        .clk(clk), .reset(reset), .raw(btn_alarm),
        .level(lvl_alarm), .press(p_alarm)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .reset(reset), .raw(btn_inc),
        .level(lvl_inc), .press(p_inc)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm (
        .clk(clk), .reset(reset), .raw(btn_arm),
        .level(lvl_arm), .press(p_arm)
    );

    logic [2:0]    state, state_nx;
    hhmm_t         edit, edit_nx, shadow, seed, hour_up, min_up;
    logic [RW-1:0] rep_cnt;
    logic          rep_started;
    logic [TW-1:0] to_cnt;
    logic          al_on, stop;
    logic          editing, hour_field, hold_ok, rep;
    logic          ev_mode, ev_alarm, ev_inc, any_ev, timed_out;

    assign seed = {core.H_out1, core.H_out0, core.M_out1, core.M_out0};

    always_comb begin
        editing = (state == ST_T_HOUR) || (state == ST_T_MIN) ||
                  (state == ST_A_HOUR) || (state == ST_A_MIN);
        hour_field = (state == ST_T_HOUR) || (state == ST_A_HOUR);
        // Any other held button pauses auto-repeat, extending the
        // rule that mode/alarm outrank inc.
        hold_ok = editing && lvl_inc && !lvl_mode && !lvl_alarm && !lvl_arm;
        rep = hold_ok && (rep_started ? (rep_cnt == REP_NEXT)
                                      : (rep_cnt == REP_FIRST));
        ev_mode   = p_mode;
        ev_alarm  = p_alarm && !p_mode;
        ev_inc    = (p_inc || rep) && !p_mode && !p_alarm;
        any_ev    = p_mode || p_alarm || p_inc || p_arm || rep;
        timed_out = editing && !any_ev && (to_cnt == TO_LAST);
    end

    always_comb begin
        hour_up = edit;
        if (edit.h1 == HOUR_MAX_TENS && edit.h0 >= HOUR_MAX_UNITS_AT_2) begin
            hour_up.h1 = '0;
            hour_up.h0 = '0;
        end else if (edit.h0 == DIGIT_MAX) begin
            hour_up.h1 = edit.h1 + 1'b1;
            hour_up.h0 = '0;
        end else begin
            hour_up.h0 = edit.h0 + 1'b1;
        end
    end

    always_comb begin
        min_up = edit;
        if (edit.m0 == DIGIT_MAX) begin
            min_up.m0 = '0;
            min_up.m1 = (edit.m1 >= MIN_MAX_TENS) ? '0 : edit.m1 + 1'b1;
        end else begin
            min_up.m0 = edit.m0 + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:
                if (ev_mode)       state_nx = ST_T_HOUR;
                else if (ev_alarm) state_nx = ST_A_HOUR;
            ST_T_HOUR:
                if (ev_mode)       state_nx = ST_T_MIN;
                else if (ev_alarm) state_nx = ST_IDLE;
            ST_T_MIN:
                if (ev_mode)       state_nx = ST_COMMIT_T;
                else if (ev_alarm) state_nx = ST_IDLE;
            ST_A_HOUR:
                if (ev_mode)       state_nx = ST_IDLE;
                else if (ev_alarm) state_nx = ST_A_MIN;
            ST_A_MIN:
                if (ev_mode)       state_nx = ST_IDLE;
                else if (ev_alarm) state_nx = ST_COMMIT_A;
            default:               state_nx = ST_IDLE;
        endcase
        if (timed_out) state_nx = ST_IDLE;
    end

    always_comb begin
        edit_nx = edit;
        if (state == ST_IDLE && ev_mode)       edit_nx = seed;
        else if (state == ST_IDLE && ev_alarm) edit_nx = shadow;
        else if (ev_inc && editing)            edit_nx = hour_field ? hour_up : min_up;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            edit        <= '0;
            shadow      <= '0;
            rep_cnt     <= '0;
            rep_started <= 1'b0;
            to_cnt      <= '0;
            al_on       <= 1'b0;
            stop        <= 1'b0;
        end else begin
            state <= state_nx;
            edit  <= edit_nx;
            if (state == ST_COMMIT_A) shadow <= edit;
            if (!hold_ok) begin
                rep_cnt     <= '0;
                rep_started <= 1'b0;
            end else if (rep) begin
                rep_cnt     <= RW'(1);
                rep_started <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
            if (!editing || any_ev || timed_out) to_cnt <= '0;
            else                                 to_cnt <= to_cnt + 1'b1;
            al_on <= al_on ^ (p_arm && !core.Alarm);
            stop  <= p_arm && core.Alarm;
        end
    end

    assign core.H_in1    = edit.h1;
    assign core.H_in0    = edit.h0;
    assign core.M_in1    = edit.m1;
    assign core.M_in0    = edit.m0;
    assign core.LD_time  = (state == ST_COMMIT_T);
    assign core.LD_alarm = (state == ST_COMMIT_A);
    assign core.AL_ON    = al_on;
    assign core.STOP_al  = stop;

endmodule

// File: tb/tb_aclock_time_setter.sv
// Scoreboard bench for aclock_time_setter: directed button sequences,
// expected output events queued and matched by a negedge monitor.
module tb_aclock_time_setter;

    localparam int K_DIG = 0, K_LDT = 1, K_LDA = 2, K_STOP = 3, K_ARM = 4;
    localparam int B_MODE = 0, B_ALARM = 1, B_INC = 2, B_ARM = 3;

    typedef struct {
        int kind;
        int val;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_mode = 1'b0, btn_alarm = 1'b0, btn_inc = 1'b0, btn_arm = 1'b0;

    aclock_time_setter_if bus ();

    aclock_time_setter dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_alarm(btn_alarm),
        .btn_inc(btn_inc), .btn_arm(btn_arm),
        .core(bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    exp_t exp_q[$];
    int   nvec = 0, nmis = 0;
    int   n_obs = 0, n_ld = 0, last_cyc = 0;
    int   cur = 0, mh = 0, mm = 0;
    int   prev = 0;
    logic prev_al = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int digits();
        return int'({bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0});
    endfunction

    function automatic int pack(int h, int m);
        return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
    endfunction

    task automatic chk(string nm, int act, int req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic observe(int kind, int val);
        exp_t e;
        n_obs++;
        if (kind == K_LDT || kind == K_LDA) n_ld++;
        if (exp_q.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL unexpected_event: kind %0d value %h, expected none (cycle %0d)",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind != K_STOP) chk("event_value", val, e.val);
            if (e.gap >= 0) chk("event_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
    endtask

    always @(negedge clk) begin : mon
        int d;
        d = digits();
        if (reset) begin
            prev    = d;
            prev_al = bus.AL_ON;
        end else begin
            if (d != prev) observe(K_DIG, d);
            prev = d;
            if (bus.LD_time)  observe(K_LDT, d);
            if (bus.LD_alarm) observe(K_LDA, d);
            if (bus.STOP_al)  observe(K_STOP, 0);
            if (bus.AL_ON != prev_al) observe(K_ARM, int'(bus.AL_ON));
            prev_al = bus.AL_ON;
        end
    end

    task automatic push(int kind, int val, int gap);
        exp_q.push_back('{kind: kind, val: val, gap: gap});
    endtask

    task automatic set_hm(int h, int m, int gap);
        int v;
        mh = h;
        mm = m;
        v  = pack(h, m);
        if (v != cur) push(K_DIG, v, gap);
        cur = v;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(int b, logic v);
        case (b)
            B_MODE:  btn_mode  = v;
            B_ALARM: btn_alarm = v;
            B_INC:   btn_inc   = v;
            default: btn_arm   = v;
        endcase
    endtask

    task automatic tap(int b);
        drive(b, 1'b1);
        tick(3);
        drive(b, 1'b0);
        tick(8);
    endtask

    task automatic inc_hour();
        set_hm((mh + 1) % 24, mm, -1);
        tap(B_INC);
    endtask

    task automatic inc_min();
        set_hm(mh, (mm + 1) % 60, -1);
        tap(B_INC);
    endtask

    task automatic seed(int h, int m);
        bus.H_out1 = 2'(h / 10);
        bus.H_out0 = 4'(h % 10);
        bus.M_out1 = 4'(m / 10);
        bus.M_out0 = 4'(m % 10);
    endtask

    task automatic outs_zero(string tag);
        chk({tag, "_H_in1"}, int'(bus.H_in1), 0);
        chk({tag, "_H_in0"}, int'(bus.H_in0), 0);
        chk({tag, "_M_in1"}, int'(bus.M_in1), 0);
        chk({tag, "_M_in0"}, int'(bus.M_in0), 0);
        chk({tag, "_LD_time"}, int'(bus.LD_time), 0);
        chk({tag, "_LD_alarm"}, int'(bus.LD_alarm), 0);
        chk({tag, "_AL_ON"}, int'(bus.AL_ON), 0);
        chk({tag, "_STOP_al"}, int'(bus.STOP_al), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        bus.Alarm = 1'b0;
        seed(14, 37);
        tick(3);
        reset = 1'b0;
        outs_zero("reset");

        // 1-cycle mode glitch must not enter time edit
        n0 = n_obs;
        btn_mode = 1'b1;
        tick(1);
        btn_mode = 1'b0;
        tick(10);
        tap(B_INC);
        chk("bounce_no_event", n_obs - n0, 0);

        // alarm edit from reset value: 23 hour increments
        tap(B_ALARM);
        for (int i = 0; i < 23; i++) inc_hour();
        tap(B_ALARM);
        push(K_LDA, cur, -1);
        tap(B_ALARM);
        tap(B_ALARM);
        inc_hour();
        tap(B_ALARM);
        push(K_LDA, cur, -1);
        tap(B_ALARM);

        // time edit seeded from 14:37
        set_hm(14, 37, -1);
        tap(B_MODE);
        inc_hour();
        tap(B_MODE);
        inc_min();
        inc_min();
        push(K_LDT, pack(15, 39), -1);
        tap(B_MODE);
        n0 = n_obs;
        tap(B_INC);
        chk("idle_after_commit", n_obs - n0, 0);

        // minute wrap and auto-repeat
        seed(10, 58);
        set_hm(10, 58, -1);
        tap(B_MODE);
        tap(B_MODE);
        inc_min();
        inc_min();
        set_hm(10, 1, -1);
        set_hm(10, 2, 10);
        set_hm(10, 3, 3);
        set_hm(10, 4, 3);
        set_hm(10, 5, 3);
        btn_inc = 1'b1;
        tick(20);
        btn_inc = 1'b0;
        tick(10);
        push(K_LDT, pack(10, 5), -1);
        tap(B_MODE);

        // timeout: 98 idle cycles survive, 100 abandon the edit
        seed(8, 15);
        set_hm(8, 15, -1);
        tap(B_MODE);
        inc_hour();
        tick(88);
        inc_hour();
        n0 = n_ld;
        tick(95);
        set_hm(8, 15, -1);
        tap(B_MODE);
        chk("timeout_no_load", n_ld - n0, 0);

        // mode+inc together: advance to minutes, hour untouched
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(8);
        inc_min();
        n0 = n_ld;
        tap(B_ALARM);
        tap(B_INC);
        chk("abort_no_load", n_ld - n0, 0);

        // arm: toggle when quiet, silence when ringing
        push(K_ARM, 1, -1);
        tap(B_ARM);
        bus.Alarm = 1'b1;
        push(K_STOP, 0, -1);
        tap(B_ARM);
        chk("al_on_kept", int'(bus.AL_ON), 1);
        bus.Alarm = 1'b0;
        push(K_ARM, 0, -1);
        tap(B_ARM);
        push(K_ARM, 1, -1);
        tap(B_ARM);

        // reset during A_MIN
        set_hm(0, 0, -1);
        tap(B_ALARM);
        inc_hour();
        tap(B_ALARM);
        inc_min();
        n0 = n_ld;
        reset = 1'b1;
        tick(1);
        outs_zero("reset_mid_edit");
        tick(2);
        reset = 1'b0;
        cur = 0;
        mh  = 0;
        mm  = 0;
        tick(20);
        chk("reset_no_load", n_ld - n0, 0);
        tap(B_ALARM);
        tap(B_ALARM);
        push(K_LDA, 0, -1);
        tap(B_ALARM);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
